// File: rtl/risc_pkg.sv
// ----------------------------------------------------------------------------
// risc_pkg
//   Shared definitions for the RISC core memory subsystem.
//   - AW / DW      : program/data memory address and data widths
//   - owner_e      : which requester owns the memory command in flight
//   - rd_pend_t    : owner of a read in its return stage, plus the read flag
//   - cnt_width()  : register width needed to hold 0..max_val (never zero)
// ----------------------------------------------------------------------------
package risc_pkg;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        OwnerIdle = 2'd0,
        OwnerCpu  = 2'd1,
        OwnerHost = 2'd2
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   rd;
    } rd_pend_t;

    // A limit of 0 still needs a 1-bit register so the compare has an operand.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Up-counter that saturates at MAX, with a clear that overrides increment.
//   Used by the memory arbiter for both its starvation and burst counters.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst    : synchronous active-high reset (count -> 0)
//   i_inc    : increment request (ignored once at MAX)
//   i_clr    : clear request (wins over i_inc)
//   o_at_max : count currently equals MAX
// ----------------------------------------------------------------------------
module sat_counter
    import risc_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max
);

    localparam int unsigned W = cnt_width(MAX);
    localparam logic [W-1:0] MaxVal = W'(MAX);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MaxVal)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_at_max = (r_cnt == MaxVal);

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Single-port memory arbiter between the RISC CPU core and the host/debug
//   loader. One access is accepted per cycle, registered as the memory command
//   for a 1-cycle-latency synchronous RAM, and the read data is routed back to
//   whichever side issued the read. A starvation limit protects the host and
//   a burst limit protects the CPU when both keep requesting.
//
// Ports
//   sys_clk, rst                   : clock; synchronous active-high reset
//   cpu_req/wr/addr/wdata          : CPU access request
//   cpu_hold                       : CPU request not accepted this cycle
//   cpu_rdata                      : last CPU read data, held
//   host_lock                      : host owns memory, CPU never accepted
//   host_req/wr/addr/wdata         : host access request
//   host_gnt                       : host request accepted this cycle
//   host_rvalid, host_rdata        : host read return pulse and data
//   mem_en/we/addr/wdata           : registered memory command
//   mem_rdata                      : memory read data, 1 cycle after command
// ----------------------------------------------------------------------------
module mem_arbiter
    import risc_pkg::*;
#(
    parameter int unsigned STARVE_MAX     = 4,
    parameter int unsigned HOST_BURST_MAX = 8
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_hold,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_lock,
    input  logic          host_req,
    input  logic          host_wr,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic w_contested;
    logic w_cpu_win;
    logic w_host_win;
    logic w_cpu_acc;
    logic w_starve_max;
    logic w_burst_max;

    assign w_contested = cpu_req & host_req;

    always_comb begin
        w_cpu_win  = 1'b0;
        w_host_win = 1'b0;
        if (rst) begin
            // Nothing is accepted while in reset.
            w_cpu_win  = 1'b0;
            w_host_win = 1'b0;
        end else if (host_lock) begin
            w_host_win = 1'b1;
        end else if (w_contested) begin
            // Burst limit beats the starvation limit so neither side can
            // monopolise the memory indefinitely.
            if (w_burst_max) begin
                w_cpu_win = 1'b1;
            end else if (w_starve_max) begin
                w_host_win = 1'b1;
            end else begin
                w_cpu_win = 1'b1;
            end
        end else begin
            w_cpu_win  = cpu_req;
            w_host_win = host_req;
        end
    end

    assign cpu_hold  = cpu_req & ~w_cpu_win;
    assign host_gnt  = host_req & w_host_win;
    assign w_cpu_acc = cpu_req & ~cpu_hold;

    // ------------------------------------------------------------------
    // Fairness counters
    // ------------------------------------------------------------------
    sat_counter #(
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .i_clk    (sys_clk),
        .i_rst    (rst),
        .i_inc    (w_contested & ~host_gnt),
        .i_clr    (host_gnt | ~host_req),
        .o_at_max (w_starve_max)
    );

    sat_counter #(
        .MAX (HOST_BURST_MAX)
    ) u_burst_cnt (
        .i_clk    (sys_clk),
        .i_rst    (rst),
        .i_inc    (w_contested & host_gnt),
        .i_clr    (w_cpu_acc | ~cpu_req),
        .o_at_max (w_burst_max)
    );

    // ------------------------------------------------------------------
    // Owner FSM and registered memory command
    // ------------------------------------------------------------------
    owner_e        r_owner;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_owner     <= OwnerIdle;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            unique case (1'b1)
                w_cpu_acc: begin
                    r_owner     <= OwnerCpu;
                    r_mem_en    <= 1'b1;
                    r_mem_we    <= cpu_wr;
                    r_mem_addr  <= cpu_addr;
                    r_mem_wdata <= cpu_wdata;
                end
                host_gnt: begin
                    r_owner     <= OwnerHost;
                    r_mem_en    <= 1'b1;
                    r_mem_we    <= host_wr;
                    r_mem_addr  <= host_addr;
                    r_mem_wdata <= host_wdata;
                end
                default: begin
                    // Address/data are left as they were; only the strobes drop.
                    r_owner  <= OwnerIdle;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // ------------------------------------------------------------------
    // Read return pipe: tags the RAM output cycle with the read's owner
    // ------------------------------------------------------------------
    rd_pend_t      r_rd_pend;
    logic [DW-1:0] r_cpu_rdata;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_rd_pend   <= '{owner: OwnerIdle, rd: 1'b0};
            r_cpu_rdata <= '0;
        end else begin
            r_rd_pend <= '{owner: r_owner, rd: r_mem_en & ~r_mem_we};
            if (r_rd_pend.rd && (r_rd_pend.owner == OwnerCpu)) begin
                r_cpu_rdata <= mem_rdata;
            end
        end
    end

    // Gated by rst so a return landing in a reset cycle is dropped.
    assign host_rvalid = r_rd_pend.rd & (r_rd_pend.owner == OwnerHost) & ~rst;
    assign host_rdata  = mem_rdata;
    assign cpu_rdata   = r_cpu_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A behavioural RAM answers the DUT's
//   memory commands; expected commands and host read data are queued when
//   stimulus is applied and compared as the DUT emits them. A second instance
//   with STARVE_MAX = 0 exercises the host burst limit.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [12:0] addr;
        logic [7:0]  wdata;
    } cmd_t;

    logic        sys_clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_wr;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_hold;
    logic [7:0]  cpu_rdata;
    logic        host_lock;
    logic        host_req;
    logic        host_wr;
    logic [12:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [7:0]  host_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    // Second instance (burst limit)
    logic        b_cpu_req;
    logic        b_host_req;
    logic        b_cpu_hold;
    logic [7:0]  b_cpu_rdata;
    logic        b_host_gnt;
    logic        b_host_rvalid;
    logic [7:0]  b_host_rdata;
    logic        b_mem_en;
    logic        b_mem_we;
    logic [12:0] b_mem_addr;
    logic [7:0]  b_mem_wdata;
    logic [7:0]  b_mem_rdata;

    logic [7:0]  ram     [0:8191];
    logic [7:0]  ref_mem [0:8191];
    cmd_t        cmd_q   [$];
    logic [7:0]  rd_q    [$];

    int n_checks;
    int n_errors;

    mem_arbiter u_dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_hold    (cpu_hold),
        .cpu_rdata   (cpu_rdata),
        .host_lock   (host_lock),
        .host_req    (host_req),
        .host_wr     (host_wr),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    mem_arbiter #(
        .STARVE_MAX     (0),
        .HOST_BURST_MAX (8)
    ) u_dut_b (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .cpu_req     (b_cpu_req),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_hold    (b_cpu_hold),
        .cpu_rdata   (b_cpu_rdata),
        .host_lock   (host_lock),
        .host_req    (b_host_req),
        .host_wr     (host_wr),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (b_host_gnt),
        .host_rvalid (b_host_rvalid),
        .host_rdata  (b_host_rdata),
        .mem_en      (b_mem_en),
        .mem_we      (b_mem_we),
        .mem_addr    (b_mem_addr),
        .mem_wdata   (b_mem_wdata),
        .mem_rdata   (b_mem_rdata)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // 1-cycle-latency synchronous RAM
    always @(posedge sys_clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: memory commands and host read returns
    always @(negedge sys_clk) begin
        cmd_t e;
        logic [7:0] d;
        if (mem_en) begin
            if (cmd_q.size() == 0) begin
                check("mem_unexpected", 32'd1, 32'd0);
            end else begin
                e = cmd_q.pop_front();
                check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                check("mem_addr", {19'd0, mem_addr}, {19'd0, e.addr});
                if (e.we) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
            end
        end
        if (host_rvalid) begin
            if (rd_q.size() == 0) begin
                check("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                d = rd_q.pop_front();
                check("host_rdata", {24'd0, host_rdata}, {24'd0, d});
            end
        end
    end

    // Drive one cycle, check the combinational grant, queue expectations.
    task automatic step(input logic c_req, input logic c_wr, input logic [12:0] c_addr,
                        input logic [7:0] c_wd, input logic h_req, input logic h_wr,
                        input logic [12:0] h_addr, input logic [7:0] h_wd,
                        input logic exp_hold, input logic exp_gnt, input logic push_rd,
                        input string tag);
        cmd_t c;
        cpu_req    = c_req;
        cpu_wr     = c_wr;
        cpu_addr   = c_addr;
        cpu_wdata  = c_wd;
        host_req   = h_req;
        host_wr    = h_wr;
        host_addr  = h_addr;
        host_wdata = h_wd;
        @(negedge sys_clk);
        check({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, exp_hold});
        check({tag, "_gnt"}, {31'd0, host_gnt}, {31'd0, exp_gnt});
        if (c_req && !exp_hold) begin
            c.we = c_wr; c.addr = c_addr; c.wdata = c_wd;
            cmd_q.push_back(c);
            if (c_wr) ref_mem[c_addr] = c_wd;
        end else if (exp_gnt) begin
            c.we = h_wr; c.addr = h_addr; c.wdata = h_wd;
            cmd_q.push_back(c);
            if (h_wr)         ref_mem[h_addr] = h_wd;
            else if (push_rd) rd_q.push_back(ref_mem[h_addr]);
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 13'h0, 8'h0, 1'b0, 1'b0, 13'h0, 8'h0, 1'b0, 1'b0, 1'b1, "idle");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic hw;
        logic bw;
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 8192; i++) begin
            ram[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        ram[16]     = 8'hA5;
        ref_mem[16] = 8'hA5;
        mem_rdata   = 8'h00;
        b_mem_rdata = 8'h00;
        rst = 1'b1;
        cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        host_lock = 0; host_req = 0; host_wr = 0; host_addr = '0; host_wdata = '0;
        b_cpu_req = 0; b_host_req = 0;

        // Reset: nothing accepted, outputs at reset values
        repeat (2) @(posedge sys_clk);
        #1;
        cpu_req = 1'b1;
        host_req = 1'b1;
        @(negedge sys_clk);
        check("rst_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_gnt", {31'd0, host_gnt}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {19'd0, mem_addr}, 32'd0);
        check("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
        check("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        cpu_req = 1'b0;
        host_req = 1'b0;

        // CPU-only read of 0x0010
        step(1'b1, 1'b0, 13'h0010, 8'h0, 1'b0, 1'b0, 13'h0, 8'h0, 1'b0, 1'b0, 1'b1, "cpu_rd");
        check("cpu_rd_mem_en", {31'd0, mem_en}, 32'd1);
        check("cpu_rd_mem_addr", {19'd0, mem_addr}, 32'h0010);
        idle(2);
        check("cpu_rdata_a5", {24'd0, cpu_rdata}, 32'h00A5);

        // Host-only write then back-to-back read of 0x1FFF
        step(1'b0, 1'b0, 13'h0, 8'h0, 1'b1, 1'b1, 13'h1FFF, 8'hFF, 1'b0, 1'b1, 1'b1, "host_wr");
        step(1'b0, 1'b0, 13'h0, 8'h0, 1'b1, 1'b0, 13'h1FFF, 8'h00, 1'b0, 1'b1, 1'b1, "host_rd");
        idle(1);
        check("host_rvalid_t3", {31'd0, host_rvalid}, 32'd1);
        check("host_rdata_ff", {24'd0, host_rdata}, 32'h00FF);
        idle(2);

        // Contention: CPU wins 4, host wins the 5th, repeating
        for (int k = 0; k < 15; k++) begin
            hw = ((k % 5) == 4);
            step(1'b1, 1'b0, 13'h0020, 8'h0, 1'b1, 1'b1, 13'h0030, 8'(k), hw, hw, 1'b1,
                 "contend");
        end
        idle(3);
        check("contend_cpu_rdata", {24'd0, cpu_rdata}, {24'd0, ref_mem[13'h0020]});

        // Burst limit (STARVE_MAX = 0 instance): 8 host wins, then one CPU win
        b_cpu_req  = 1'b1;
        b_host_req = 1'b1;
        for (int k = 0; k < 18; k++) begin
            bw = ((k % 9) != 8);
            @(negedge sys_clk);
            check("burst_gnt", {31'd0, b_host_gnt}, {31'd0, bw});
            check("burst_hold", {31'd0, b_cpu_hold}, {31'd0, bw});
            @(posedge sys_clk);
            #1;
        end
        b_cpu_req  = 1'b0;
        b_host_req = 1'b0;

        // host_lock load: 32 host writes while the CPU is held, then read some back
        host_lock = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b1, 13'h0100, 8'h77, 1'b1, 1'b1, 13'h0200 + 13'(i), 8'(i * 7 + 1),
                 1'b1, 1'b1, 1'b1, "lock_wr");
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 13'h0100, 8'h77, 1'b1, 1'b0, 13'h0200 + 13'(i * 9), 8'h0,
                 1'b1, 1'b1, 1'b1, "lock_rd");
        end
        host_lock = 1'b0;
        step(1'b1, 1'b1, 13'h0100, 8'h77, 1'b0, 1'b0, 13'h0, 8'h0, 1'b0, 1'b0, 1'b1, "unlock");
        idle(3);

        // Reset during t+1 of a host read: return is dropped
        step(1'b0, 1'b0, 13'h0, 8'h0, 1'b1, 1'b0, 13'h0005, 8'h0, 1'b0, 1'b1, 1'b0, "rst_rd");
        host_req = 1'b0;
        rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check("midrst_mem_en", {31'd0, mem_en}, 32'd0);
        check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
        check("midrst_mem_addr", {19'd0, mem_addr}, 32'd0);
        check("midrst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("midrst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
        check("midrst_rvalid", {31'd0, host_rvalid}, 32'd0);
        rst = 1'b0;
        idle(3);

        check("cmd_q_drained", cmd_q.size(), 32'd0);
        check("rd_q_drained", rd_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing the 8-bit program/data memory between the RISC CPU core and a host/debug loader port. It accepts at most one access per cycle, drives a registered command to a 1-cycle-latency synchronous RAM, and routes read data back to the winning requester. It stalls the CPU through `cpu_hold`, which gates the CPU's clock enable. A starvation counter and a burst limit bound the wait on either side.

## Interface
- `AW`, 13, memory address width
- `DW`, 8, memory data width
- `STARVE_MAX`, 4, contested cycles the host may lose before it is forced to win one
- `HOST_BURST_MAX`, 8, consecutive contested host wins before the CPU is forced to win one

Ports:
- `sys_clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `cpu_req`  in  1  CPU access request (`rd | wr`)
- `cpu_wr`  in  1  1 = write, 0 = read
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_hold`  out  1  CPU must freeze this cycle; request not accepted
- `cpu_rdata`  out  DW  last CPU read data, held until the next CPU read returns
- `host_lock`  in  1  host owns memory exclusively; CPU is never accepted
- `host_req`  in  1  host access request
- `host_wr`  in  1  1 = write, 0 = read
- `host_addr`  in  AW  host address
- `host_wdata`  in  DW  host write data
- `host_gnt`  out  1  host access accepted this cycle
- `host_rvalid`  out  1  `host_rdata` valid (read return pulse)
- `host_rdata`  out  DW  host read data
- `mem_en`  out  1  memory command valid
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid 1 cycle after a read command

## Operation
- Arbitration is combinational from the current requests and registered counters:
  - Only one side requesting: that side wins.
  - `host_lock = 1`: the host always wins and `cpu_hold = cpu_req`.
  - Contested, no lock: the CPU wins by default.
  - Contested, no lock, `starve_cnt == STARVE_MAX`: the host wins.
  - Contested, no lock, `burst_cnt == HOST_BURST_MAX`: the CPU wins. This rule overrides the starve rule.
- `cpu_hold = cpu_req & ~cpu_win`; `host_gnt = host_req & host_win`.
- A CPU access is accepted every cycle in which `cpu_req & ~cpu_hold`. Repeated acceptance of the same held read or write is idempotent, and no edge detection is done.
- `starve_cnt`:
  - Increments, saturating at `STARVE_MAX`, on each contested cycle the host loses.
  - Clears on every `host_gnt`.
  - Clears whenever `host_req = 0`.
- `burst_cnt`:
  - Increments, saturating at `HOST_BURST_MAX`, on each contested host win.
  - Clears on any CPU acceptance.
  - Clears whenever `cpu_req = 0`.
- Owner FSM register `owner`, with states IDLE, CPU, HOST, records the winner of the previous cycle:
  - Next state is CPU on a CPU acceptance, HOST on `host_gnt`, otherwise IDLE.
  - A second register `rd_pend` stores `owner` together with the read flag, for read-data routing.

## Timing
- Cycle t (acceptance): winner decided; `host_gnt`/`cpu_hold` valid combinationally.
- Cycle t+1: `mem_en = 1`, `mem_we`, `mem_addr`, `mem_wdata` driven from the registered winner's command.
- Cycle t+2, read by the host: `host_rvalid = 1` for one cycle, `host_rdata = mem_rdata`.
- Cycle t+2, read by the CPU: `cpu_rdata` is loaded from `mem_rdata` at the end of t+2 and holds.
- Writes produce no return.
- Throughput is one access per cycle, back-to-back, with either owner.
- Reset values: `mem_en`, `mem_we`, `host_rvalid` = 0; `mem_addr`, `mem_wdata`, `cpu_rdata` = 0; `owner` = IDLE; both counters = 0.
- `cpu_hold` and `host_gnt` are combinational and therefore low in reset only when the requests are low. During `rst`, the arbiter accepts nothing: `cpu_hold = cpu_req` and `host_gnt = 0`.
- Reset mid-operation: an in-flight read return in t+1/t+2 is dropped; no `host_rvalid` and no `cpu_rdata` update occur.
- `host_lock` toggling takes effect in the same cycle. Commands already registered complete normally.

## Structure
- Put `AW`, `DW` and the owner enum (IDLE/CPU/HOST) in the shared `risc_pkg` package.
- One natural sub-module: `sat_counter` (parameterised max, increment, clear), instantiated twice, for `starve_cnt` and `burst_cnt`.
- The arbitration logic, command register and return pipe stay in `mem_arbiter`.

## Test plan
- **CPU-only read:** `cpu_req=1`, `cpu_addr=0x0010`, memory holds `0xA5` → `cpu_hold=0`; `mem_en=1`/`mem_addr=0x0010` at t+1; `cpu_rdata=0xA5` after t+2.
- **Host-only write then read:** write `0xFF` to `0x1FFF`, then read it back to back → `host_gnt` high both cycles; `host_rvalid` at t+3 with `host_rdata=0xFF`.
- **Contention with starvation:** `cpu_req` and `host_req` both held high → CPU wins 4 cycles (`cpu_hold=0`); 5th cycle `host_gnt=1` and `cpu_hold=1`; the pattern repeats.
- **Burst limit:** `host_lock=0`, forced host wins with `STARVE_MAX=0` → at most 8 consecutive `host_gnt`, then one CPU acceptance.
- **`host_lock` load:** `host_lock=1`, CPU requesting, host writes 32 bytes → `cpu_hold` high throughout; all 32 writes appear on `mem_*` in order.
- **Reset mid-read:** `rst` asserted in t+1 of a host read → no `host_rvalid`; all outputs at reset values in the following cycle.
